// File: rtl/frog_pkg.sv
// Shared types and playfield constants for the frog hop controller.
// Default bounds keep a 32x32 frog fully on a 640x480 screen.
package frog_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_HOP, ST_DEAD} frog_state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} hop_dir_t;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int FROG_SIZE = 32;

    localparam int DEF_X_MIN = 0;
    localparam int DEF_X_MAX = SCREEN_W - FROG_SIZE;
    localparam int DEF_Y_MIN = 8;
    localparam int DEF_Y_MAX = SCREEN_H - 40;

    localparam int DEF_START_X = 320;
    localparam int DEF_START_Y = 440;

endpackage

// File: rtl/frog_hop_ctrl_key_edge_latch.sv
// Detects rising key edges, priority-encodes them (up>down>left>right)
// and holds a pending hop request until the controller clears it.
module key_edge_latch
    import frog_pkg::*;
(
    input  logic       CLK,
    input  logic       RESETn,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       capture_en,
    input  logic       clear,
    output logic       pending,
    output logic [1:0] pend_dir
);

    logic [3:0] key_d, key_q;
    logic [3:0] key_edge;
    logic       pending_d, pending_q;
    hop_dir_t   dir_d, dir_q;

    assign key_d    = {up, down, left, right};
    assign key_edge = key_d & ~key_q;

    // Clear wins over a same-cycle edge; edges outside IDLE are dropped.
    always_comb begin
        pending_d = pending_q;
        dir_d     = dir_q;
        if (clear) begin
            pending_d = 1'b0;
        end else if (capture_en && (|key_edge)) begin
            pending_d = 1'b1;
            if (key_edge[3])      dir_d = DIR_UP;
            else if (key_edge[2]) dir_d = DIR_DOWN;
            else if (key_edge[1]) dir_d = DIR_LEFT;
            else                  dir_d = DIR_RIGHT;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            key_q     <= '0;
            pending_q <= 1'b0;
            dir_q     <= DIR_UP;
        end else begin
            key_q     <= key_d;
            pending_q <= pending_d;
            dir_q     <= dir_d;
        end
    end

    assign pending  = pending_q;
    assign pend_dir = dir_q;

endmodule

// File: rtl/frog_hop_ctrl.sv
// Frog position controller: animated fixed-distance hops, per-tick river
// drift, playfield bounds checking and death/respawn handling.
module frog_hop_ctrl
    import frog_pkg::*;
#(
    parameter int XW        = 11,
    parameter int YW        = 11,
    parameter int START_X   = DEF_START_X,
    parameter int START_Y   = DEF_START_Y,
    parameter int HOP_DIST  = 32,
    parameter int HOP_STEPS = 8,
    parameter int X_MIN     = DEF_X_MIN,
    parameter int X_MAX     = DEF_X_MAX,
    parameter int Y_MIN     = DEF_Y_MIN,
    parameter int Y_MAX     = DEF_Y_MAX,
    parameter int DW        = 4
) (
    input  logic          CLK,
    input  logic          RESETn,
    input  logic          tick,
    input  logic          up,
    input  logic          down,
    input  logic          left,
    input  logic          right,
    input  logic          carry_en,
    input  logic [DW-1:0] carry_vx,
    input  logic          respawn,
    output logic [XW-1:0] ObjectStartX,
    output logic [YW-1:0] ObjectStartY,
    output logic          hopping,
    output logic [1:0]    hop_dir,
    output logic          hop_done,
    output logic          out_of_bounds
);

    localparam int XS   = XW + 2;
    localparam int YS   = YW + 2;
    localparam int STEP = HOP_DIST / HOP_STEPS;
    localparam int CW   = $clog2(HOP_STEPS + 1);

    localparam logic signed [XS-1:0] X_LO   = XS'(X_MIN);
    localparam logic signed [XS-1:0] X_HI   = XS'(X_MAX);
    localparam logic signed [XS-1:0] HOP_X  = XS'(HOP_DIST);
    localparam logic signed [XS-1:0] STEP_X = XS'(STEP);
    localparam logic signed [YS-1:0] Y_LO   = YS'(Y_MIN);
    localparam logic signed [YS-1:0] Y_HI   = YS'(Y_MAX);
    localparam logic signed [YS-1:0] HOP_Y  = YS'(HOP_DIST);
    localparam logic [CW-1:0]        LAST_STEP = CW'(HOP_STEPS - 1);

    frog_state_t    state_d, state_q;
    hop_dir_t       dir_d, dir_q;
    logic [XW-1:0]  x_d, x_q;
    logic [YW-1:0]  y_d, y_q;
    logic [CW-1:0]  step_d, step_q;
    logic           hopping_d, hopping_q;
    logic           hop_done_d, hop_done_q;
    logic           oob_d, oob_q;

    logic           pending;
    logic [1:0]     pend_dir;
    logic           pend_clear;
    logic           target_ok;

    logic signed [XS-1:0] x_ext, vx_ext, tx, dx, nx;
    logic signed [YS-1:0] y_ext, ty;

    key_edge_latch u_keys (
        .CLK        (CLK),
        .RESETn     (RESETn),
        .up         (up),
        .down       (down),
        .left       (left),
        .right      (right),
        .capture_en (state_q == ST_IDLE),
        .clear      (pend_clear),
        .pending    (pending),
        .pend_dir   (pend_dir)
    );

    assign x_ext  = {2'b00, x_q};
    assign y_ext  = {2'b00, y_q};
    assign vx_ext = {{(XS-DW){carry_vx[DW-1]}}, carry_vx};

    // Hop acceptance looks at the full-distance landing spot before any motion.
    always_comb begin
        tx = x_ext;
        ty = y_ext;
        case (hop_dir_t'(pend_dir))
            DIR_UP:    ty = y_ext - HOP_Y;
            DIR_DOWN:  ty = y_ext + HOP_Y;
            DIR_LEFT:  tx = x_ext - HOP_X;
            default:   tx = x_ext + HOP_X;
        endcase
        target_ok = (tx >= X_LO) && (tx <= X_HI) && (ty >= Y_LO) && (ty <= Y_HI);
    end

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        x_d        = x_q;
        y_d        = y_q;
        step_d     = step_q;
        hop_done_d = 1'b0;
        oob_d      = 1'b0;
        pend_clear = 1'b0;
        dx         = '0;
        nx         = x_ext;
        if (respawn) begin
            state_d    = ST_IDLE;
            x_d        = XW'(START_X);
            y_d        = YW'(START_Y);
            step_d     = '0;
            pend_clear = 1'b1;
        end else if (tick && (state_q != ST_DEAD)) begin
            if (state_q == ST_IDLE) begin
                if (pending) begin
                    pend_clear = 1'b1;
                    if (target_ok) begin
                        state_d = ST_HOP;
                        dir_d   = hop_dir_t'(pend_dir);
                        step_d  = '0;
                    end
                end
            end else begin
                case (dir_q)
                    DIR_UP:    y_d = y_q - YW'(STEP);
                    DIR_DOWN:  y_d = y_q + YW'(STEP);
                    DIR_LEFT:  dx  = -STEP_X;
                    default:   dx  = STEP_X;
                endcase
                if (step_q == LAST_STEP) begin
                    state_d    = ST_IDLE;
                    step_d     = '0;
                    hop_done_d = 1'b1;
                end else begin
                    step_d = step_q + CW'(1);
                end
            end
            // Drift and hop step combine before the bounds check; leaving the field kills.
            nx = x_ext + dx + (carry_en ? vx_ext : '0);
            if (nx < X_LO) begin
                x_d        = XW'(X_MIN);
                state_d    = ST_DEAD;
                oob_d      = 1'b1;
                hop_done_d = 1'b0;
            end else if (nx > X_HI) begin
                x_d        = XW'(X_MAX);
                state_d    = ST_DEAD;
                oob_d      = 1'b1;
                hop_done_d = 1'b0;
            end else begin
                x_d = nx[XW-1:0];
            end
        end
        hopping_d = (state_d == ST_HOP);
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q    <= ST_IDLE;
            dir_q      <= DIR_UP;
            x_q        <= XW'(START_X);
            y_q        <= YW'(START_Y);
            step_q     <= '0;
            hopping_q  <= 1'b0;
            hop_done_q <= 1'b0;
            oob_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            x_q        <= x_d;
            y_q        <= y_d;
            step_q     <= step_d;
            hopping_q  <= hopping_d;
            hop_done_q <= hop_done_d;
            oob_q      <= oob_d;
        end
    end

    assign ObjectStartX  = x_q;
    assign ObjectStartY  = y_q;
    assign hopping       = hopping_q;
    assign hop_dir       = dir_q;
    assign hop_done      = hop_done_q;
    assign out_of_bounds = oob_q;

endmodule

// File: tb/tb_frog_hop_ctrl.sv
// Directed bench for frog_hop_ctrl: hops, rejection at the edge, drift,
// drift death, respawn priority and asynchronous reset mid-hop.
module tb_frog_hop_ctrl;

    logic        CLK;
    logic        RESETn;
    logic        tick;
    logic        up, down, left, right;
    logic        carry_en;
    logic [3:0]  carry_vx;
    logic        respawn;
    logic [10:0] ObjectStartX;
    logic [10:0] ObjectStartY;
    logic        hopping;
    logic [1:0]  hop_dir;
    logic        hop_done;
    logic        out_of_bounds;

    int total;
    int bad;

    frog_hop_ctrl dut (
        .CLK           (CLK),
        .RESETn        (RESETn),
        .tick          (tick),
        .up            (up),
        .down          (down),
        .left          (left),
        .right         (right),
        .carry_en      (carry_en),
        .carry_vx      (carry_vx),
        .respawn       (respawn),
        .ObjectStartX  (ObjectStartX),
        .ObjectStartY  (ObjectStartY),
        .hopping       (hopping),
        .hop_dir       (hop_dir),
        .hop_done      (hop_done),
        .out_of_bounds (out_of_bounds)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // keys = {up, down, left, right}, held for one clock edge then released
    task automatic pressKeys(input logic [3:0] keys);
        @(negedge CLK);
        {up, down, left, right} = keys;
        @(negedge CLK);
        {up, down, left, right} = 4'b0000;
    endtask

    task automatic applyStimulus(input logic t, input logic r);
        @(negedge CLK);
        tick    = t;
        respawn = r;
        @(negedge CLK);
        tick    = 1'b0;
        respawn = 1'b0;
    endtask

    task automatic hopOnce(input logic [3:0] keys);
        pressKeys(keys);
        repeat (9) applyStimulus(1'b1, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        RESETn = 1'b0;
        tick = 1'b0; respawn = 1'b0;
        {up, down, left, right} = 4'b0000;
        carry_en = 1'b0; carry_vx = 4'h0;
        #12;
        checkOutput("rst_x", ObjectStartX, 320);
        checkOutput("rst_y", ObjectStartY, 440);
        checkOutput("rst_hopping", hopping, 0);
        checkOutput("rst_dir", hop_dir, 0);
        checkOutput("rst_done", hop_done, 0);
        checkOutput("rst_oob", out_of_bounds, 0);
        @(negedge CLK);
        RESETn = 1'b1;

        // Up and right pressed together: up wins; acceptance tick does not move
        pressKeys(4'b1001);
        applyStimulus(1'b1, 1'b0);
        checkOutput("up_accept_y", ObjectStartY, 440);
        checkOutput("up_accept_hopping", hopping, 1);
        checkOutput("up_dir", hop_dir, 0);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput($sformatf("up_y_%0d", k), ObjectStartY, 440 - 4 * k);
            checkOutput($sformatf("up_hopping_%0d", k), hopping, (k < 8) ? 1 : 0);
            checkOutput($sformatf("up_done_%0d", k), hop_done, (k == 8) ? 1 : 0);
            checkOutput($sformatf("up_x_%0d", k), ObjectStartX, 320);
        end
        @(negedge CLK);
        checkOutput("up_done_after", hop_done, 0);

        // Walk right to the edge, then a right hop must be rejected
        repeat (9) hopOnce(4'b0001);
        checkOutput("edge_x", ObjectStartX, 608);
        pressKeys(4'b0001);
        applyStimulus(1'b1, 1'b0);
        checkOutput("reject_x", ObjectStartX, 608);
        checkOutput("reject_hopping", hopping, 0);
        checkOutput("reject_done", hop_done, 0);
        hopOnce(4'b0010);
        checkOutput("left_back_x", ObjectStartX, 576);
        checkOutput("left_back_dir", hop_dir, 2);
        checkOutput("left_back_done", hop_done, 1);

        // Down from the bottom row is out of range
        applyStimulus(1'b0, 1'b1);
        checkOutput("respawn_x", ObjectStartX, 320);
        checkOutput("respawn_y", ObjectStartY, 440);
        pressKeys(4'b0100);
        applyStimulus(1'b1, 1'b0);
        checkOutput("down_reject_hopping", hopping, 0);
        checkOutput("down_reject_y", ObjectStartY, 440);

        // Left hop with drift -3: each hop tick moves -7
        pressKeys(4'b0010);
        applyStimulus(1'b1, 1'b0);
        checkOutput("drift_accept_x", ObjectStartX, 320);
        carry_en = 1'b1; carry_vx = 4'hD;
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput($sformatf("drift_x_%0d", k), ObjectStartX, 320 - 7 * k);
        end
        checkOutput("drift_done", hop_done, 1);
        carry_en = 1'b0; carry_vx = 4'h0;

        // Hop left down to X=8, drift to 2, then drift off the field
        repeat (8) hopOnce(4'b0010);
        checkOutput("near_edge_x", ObjectStartX, 8);
        carry_en = 1'b1; carry_vx = 4'hD;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("drift_to_2", ObjectStartX, 2);
        checkOutput("no_oob_yet", out_of_bounds, 0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("clamp_x", ObjectStartX, 0);
        checkOutput("oob_pulse", out_of_bounds, 1);
        checkOutput("dead_hopping", hopping, 0);
        @(negedge CLK);
        checkOutput("oob_single", out_of_bounds, 0);
        carry_vx = 4'h3;
        pressKeys(4'b1000);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("dead_frozen_x", ObjectStartX, 0);
        checkOutput("dead_frozen_y", ObjectStartY, 440);
        checkOutput("dead_hopping2", hopping, 0);
        checkOutput("dead_oob2", out_of_bounds, 0);
        carry_en = 1'b0; carry_vx = 4'h0;

        // Respawn beats a same-cycle tick
        applyStimulus(1'b1, 1'b1);
        checkOutput("rsp_x", ObjectStartX, 320);
        checkOutput("rsp_y", ObjectStartY, 440);
        checkOutput("rsp_hopping", hopping, 0);
        checkOutput("rsp_done", hop_done, 0);
        checkOutput("rsp_oob", out_of_bounds, 0);
        pressKeys(4'b1000);
        applyStimulus(1'b1, 1'b0);
        checkOutput("rsp_up_accept", hopping, 1);
        repeat (4) applyStimulus(1'b1, 1'b0);
        checkOutput("mid_hop_y", ObjectStartY, 424);

        // Asynchronous reset between clock edges
        #2;
        RESETn = 1'b0;
        #1;
        checkOutput("async_x", ObjectStartX, 320);
        checkOutput("async_y", ObjectStartY, 440);
        checkOutput("async_hopping", hopping, 0);
        @(negedge CLK);
        RESETn = 1'b1;
        applyStimulus(1'b1, 1'b0);
        checkOutput("post_rst_y", ObjectStartY, 440);
        checkOutput("post_rst_hopping", hopping, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
